fifo_rtl: RTL and testbench
===========================

FIFO_RTL -- requirements
Module: fifo_rtl

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of storage entries; it must be a power of two and at least 2.

Interface
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-006 data_in  input  WIDTH  write data, sampled when a write is accepted.
REQ-007 w_in  input  1  write request.
REQ-008 r_in  input  1  read request.
REQ-009 w_full  output  1  high when the FIFO holds DEPTH entries.
REQ-010 r_empty  output  1  high when the FIFO holds 0 entries.
REQ-011 data_out  output  WIDTH  registered read data.
REQ-012 fill_count  output  log2(DEPTH)+1  number of stored entries, range 0..DEPTH.

Function
REQ-013 Storage SHALL be a DEPTH x WIDTH memory addressed by wr_ptr and rd_ptr; each pointer is log2(DEPTH)+1 bits wide.
REQ-014 A write SHALL be accepted on a rising clk edge when w_in=1 and w_full=0 before that edge; the block stores data_in at wr_ptr[low bits] and increments wr_ptr by 1.
REQ-015 A read SHALL be accepted on a rising clk edge when r_in=1 and r_empty=0 before that edge; the block loads data_out from rd_ptr[low bits] and increments rd_ptr by 1.
REQ-016 Read latency SHALL be 1 cycle: data_out is valid on the edge that accepts the read.
REQ-017 data_out SHALL hold its last value when no read is accepted.
REQ-018 Pointers SHALL wrap modulo 2*DEPTH through natural binary overflow; storage indexing SHALL use only the low log2(DEPTH) bits.
REQ-019 r_empty SHALL be 1 when wr_ptr equals rd_ptr.
REQ-020 w_full SHALL be 1 when the pointer MSBs differ and the low bits are equal.
REQ-021 w_full, r_empty and fill_count SHALL be decoded only from registered pointers, with no combinational path from w_in, r_in or data_in.
REQ-022 fill_count SHALL equal wr_ptr minus rd_ptr, computed modulo 2*DEPTH.
REQ-023 A write request while full SHALL be ignored: memory, wr_ptr and data are unchanged and no error flag is raised.
REQ-024 A read request while empty SHALL be ignored: rd_ptr and data_out are unchanged.
REQ-025 When both requests occur in one cycle and the FIFO is neither full nor empty, both SHALL be accepted and fill_count is unchanged.
REQ-026 When both requests occur and the FIFO is empty, only the write SHALL be accepted; the new word is readable no earlier than the next edge.
REQ-027 When both requests occur and the FIFO is full, only the read SHALL be accepted.
REQ-028 Ordering SHALL be strict first-in first-out, with no loss or duplication of data.

Reset
REQ-029 While rst=0, wr_ptr and rd_ptr SHALL be 0, data_out SHALL be 0, r_empty SHALL be 1, w_full SHALL be 0 and fill_count SHALL be 0, independent of clk.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Assertion of rst mid-operation SHALL discard all stored entries immediately.
REQ-032 w_in and r_in SHALL be don't-care, including X, while rst=0.
REQ-033 The first access SHALL be honoured on the first rising edge after rst deasserts.

Verification
REQ-034 Reset: hold rst=0 for 2 edges, then release -> r_empty=1, w_full=0, fill_count=0, data_out=0.
REQ-035 Fill: write 16 random words on consecutive cycles with r_in=0 -> w_full=1 after the 16th write, fill_count=16; a 17th write is ignored and fill_count stays 16.
REQ-036 Drain: read 16 times -> data_out matches the written words in order, one per cycle; r_empty=1 after the last read; further reads leave data_out unchanged.
REQ-037 Wrap: repeat fill/drain three times with mixed write/read bursts -> no mismatch, and flags are correct at every pointer wrap.
REQ-038 Simultaneous access: with 5 entries stored, assert w_in=1 and r_in=1 for 10 cycles -> fill_count stays 5 and output order is preserved; on an empty FIFO, both asserted -> only the write is accepted.
REQ-039 Mid-operation reset: with 8 entries stored, pulse rst=0 between edges -> flags and counts reset immediately; a subsequent read is ignored until a write occurs.

Source files
------------

// File: rtl/fifo_rtl.sv
// Synchronous single-clock FIFO with registered read data and occupancy count.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module fifo_rtl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       w_in,
  input  logic                       r_in,
  output logic                       w_full,
  output logic                       r_empty,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     fill_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // Status comes only from registered pointers, so no request reaches the flags.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_addr == rd_addr);

  assign wr_en = w_in && !full;
  assign rd_en = r_in && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset; emptied pointers make it unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= data_in;
    end
  end

  assign w_full     = full;
  assign r_empty    = empty;
  assign data_out   = data_out_q;
  assign fill_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_fifo_rtl.sv
// Directed self-checking bench for fifo_rtl: reset, fill/drain, wrap,
// simultaneous access and mid-operation reset against a queue model.
module tb_fifo_rtl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             w_in;
  logic             r_in;
  logic             w_full;
  logic             r_empty;
  logic [WIDTH-1:0] data_out;
  logic [4:0]       fill_count;

  int checkCount = 0;
  int errorCount = 0;

  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] modelOut;

  fifo_rtl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .w_in       (w_in),
    .r_in       (r_in),
    .w_full     (w_full),
    .r_empty    (r_empty),
    .data_out   (data_out),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock of stimulus; the queue model decides what the FIFO should accept.
  task automatic applyStimulus(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit wasFull;
    bit wasEmpty;
    w_in     = w;
    r_in     = r;
    data_in  = d;
    wasFull  = (modelQ.size() == DEPTH);
    wasEmpty = (modelQ.size() == 0);
    @(posedge clk);
    if (r && !wasEmpty) modelOut = modelQ.pop_front();
    if (w && !wasFull) modelQ.push_back(d);
    #1;
    w_in = 1'b0;
    r_in = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".fill"},  32'(fill_count), 32'(modelQ.size()));
    checkOutput({tag, ".full"},  32'(w_full),     32'(modelQ.size() == DEPTH));
    checkOutput({tag, ".empty"}, 32'(r_empty),    32'(modelQ.size() == 0));
    checkOutput({tag, ".dout"},  32'(data_out),   32'(modelOut));
  endtask

  initial begin
    rst      = 1'b0;
    w_in     = 1'b0;
    r_in     = 1'b0;
    data_in  = '0;
    modelOut = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.empty", 32'(r_empty), 32'd1);
    checkOutput("reset.full",  32'(w_full),  32'd0);
    checkOutput("reset.fill",  32'(fill_count), 32'd0);
    checkOutput("reset.dout",  32'(data_out), 32'd0);
    rst = 1'b1;

    // Fill with A0..AF, then one ignored write while full
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 8'hA0 + 8'(i));
      checkOutput("fill.count", 32'(fill_count), 32'(i + 1));
    end
    checkOutput("fill.full16",  32'(w_full),  32'd1);
    checkOutput("fill.empty16", 32'(r_empty), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("fill.ignored.count", 32'(fill_count), 32'd16);
    checkOutput("fill.ignored.full",  32'(w_full),     32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("drain.dout",  32'(data_out),   32'(8'hA0 + 8'(i)));
      checkOutput("drain.count", 32'(fill_count), 32'(DEPTH - 1 - i));
    end
    checkOutput("drain.empty", 32'(r_empty), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("drain.extra.dout",  32'(data_out),   32'hAF);
    checkOutput("drain.extra.count", 32'(fill_count), 32'd0);

    // Mixed bursts carry both pointers through several wraps
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 12; i++) begin
        applyStimulus(1'b1, 1'b0, 8'(8'h10 * (round + 1) + i));
        checkState("wrap.w1");
      end
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkState("wrap.r1");
      end
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b1, 1'b0, 8'(8'h80 + 8'h10 * round + i));
        checkState("wrap.w2");
      end
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, 1'b1, 8'(8'hC0 + 8'h08 * round + i));
        checkState("wrap.wr");
      end
      for (int i = 0; i < 20; i++) begin
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkState("wrap.r2");
      end
    end

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h60 + i));
      checkOutput("simul.count", 32'(fill_count), 32'd5);
      checkState("simul");
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkState("simul.drain");
    end
    applyStimulus(1'b1, 1'b1, 8'h3C);
    checkOutput("simul.empty.count", 32'(fill_count), 32'd1);
    checkOutput("simul.empty.dout",  32'(data_out),   32'h69);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("simul.empty.readback", 32'(data_out), 32'h3C);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(8'hE0 + i));
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("simul.full.count", 32'(fill_count), 32'd15);
    checkOutput("simul.full.dout",  32'(data_out),   32'hE0);
    checkState("simul.full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    checkState("simul.full.drain");

    // Asynchronous reset pulse between edges with 8 entries stored
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h90 + i));
    checkOutput("midrst.pre.count", 32'(fill_count), 32'd8);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst.empty", 32'(r_empty),    32'd1);
    checkOutput("midrst.full",  32'(w_full),     32'd0);
    checkOutput("midrst.fill",  32'(fill_count), 32'd0);
    checkOutput("midrst.dout",  32'(data_out),   32'd0);
    #1 rst = 1'b1;
    modelQ.delete();
    modelOut = '0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkState("midrst.read");
    applyStimulus(1'b1, 1'b0, 8'h5A);
    checkState("midrst.write");
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("midrst.readback", 32'(data_out), 32'h5A);
    checkState("midrst.final");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
